rom_rd_arbiter: RTL and testbench

Two-port read arbiter that shares the single 4x4 synchronous ROM between two requesters. It accepts address requests, grants them round-robin, and drives the ROM cs/rd_en/addr strobes for exactly one cycle per access. It waits a fixed ROM read latency, captures the ROM data, and returns it to the winning requester with a one-cycle valid pulse. It sits between the requesting datapath blocks and the ROM instance and is the only driver of the ROM control pins.

---
 rtl/rom_rd_arbiter.sv | 112 +++++++++++
 tb/tb_rom_rd_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rom_rd_arbiter.sv
// Two-port round-robin read arbiter in front of a small synchronous ROM.
// One access at a time: sample requests in IDLE, strobe the ROM for one
// cycle, wait out the ROM latency, capture data and pulse rvalid.
module rom_rd_arbiter #(
  parameter int AW      = 2,
  parameter int DW      = 4,
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          rom_cs,
  output logic          rom_rd_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  // A latency outside what the 3-bit wait counter can express is unusable.
  if (ROM_LAT < 1 || ROM_LAT > 8) begin : g_bad_lat
    $error("rom_rd_arbiter: ROM_LAT=%0d outside 1..8", ROM_LAT);
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(ROM_LAT - 1);

  state_t     state;
  logic       ptr;   // requester favoured on a tie
  logic       win;   // requester owning the current access
  logic [2:0] cnt;
  logic       pick;

  // Single request wins outright; a tie goes to ptr.
  assign pick = (req0 && req1) ? ptr : req1;

  // Arbiter FSM; every output is a register so strobes are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      win       <= 1'b0;
      cnt       <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      rom_cs    <= 1'b0;
      rom_rd_en <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rom_cs    <= 1'b0;
      rom_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            // Strobes are set here so they are high during the ISSUE cycle.
            win       <= pick;
            rom_addr  <= pick ? addr1 : addr0;
            gnt0      <= ~pick;
            gnt1      <= pick;
            rom_cs    <= 1'b1;
            rom_rd_en <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ptr   <= ~win;
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (win) begin
              rdata1  <= rom_data;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= rom_data;
              rvalid0 <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Scoreboard bench: two arbiters (ROM latency 1 and 3) share one random
// requester stream. A transaction-level model predicts grant/response
// cycles and data; per-instance monitors pop and compare on DUT pulses.
module tb_rom_rd_arbiter;

  typedef struct {
    int port;
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [1:0] addr0, addr1;
  bit         done;

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rom_f(input int a);
    case (a)
      0: return 'hA;
      1: return 'h5;
      2: return 'hC;
      default: return 'h3;
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input int lat,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s lat=%0d actual=%0d expected=%0d", name, lat, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    logic       gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [3:0] rdata0, rdata1, rom_data, garbage;
    logic       rom_cs, rom_rd_en;
    logic [1:0] rom_addr;

    rom_rd_arbiter #(.AW(2), .DW(4), .ROM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .rom_cs(rom_cs), .rom_rd_en(rom_rd_en), .rom_addr(rom_addr),
      .rom_data(rom_data), .busy(busy)
    );

    // ROM: data for a read sampled at edge E is valid for sampling at E+LAT;
    // otherwise the bus carries noise that must never be captured.
    logic       pv[LAT];
    logic [1:0] pa[LAT];
    initial for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pa[i] = 2'd0; end
    always @(posedge clk) begin
      pv[0] <= rom_cs & rom_rd_en;
      pa[0] <= rom_addr;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
    always @(negedge clk) garbage = 4'($urandom);
    assign rom_data = pv[LAT-1] ? 4'(rom_f(int'(pa[LAT-1]))) : garbage;

    // Reference model: one access per LAT+3 cycles, tie goes to the port
    // that lost the previous grant, reset forgets everything in flight.
    int  tcyc = 0, free_at = 0, start = -100, rst_cyc = -1, mptr = 0;
    ev_t gq[$];
    ev_t rq[$];
    always @(posedge clk) begin
      int w, a;
      tcyc++;
      if (rst) begin
        mptr    = 0;
        free_at = tcyc + 1;
        start   = -100;
        rst_cyc = tcyc;
      end else if (tcyc >= free_at && (req0 || req1)) begin
        w = (req0 && req1) ? mptr : (req1 ? 1 : 0);
        a = (w == 1) ? int'(addr1) : int'(addr0);
        gq.push_back('{w, tcyc, a, 0});
        rq.push_back('{w, tcyc + LAT + 1, a, rom_f(a)});
        free_at = tcyc + LAT + 3;
        mptr    = 1 - w;
        start   = tcyc;
      end
    end

    // Monitor: consumes expected events as the DUT presents them.
    int  gi = 0, ri = 0, sh0 = 0, sh1 = 0, sh_addr = 0;
    bit  prev_cs = 1'b0, fin = 1'b0;
    always @(negedge clk) begin
      ev_t e;
      bit  bexp;
      if (tcyc > 0) begin
        if (rst_cyc == tcyc) begin
          gi = gq.size(); ri = rq.size();
          sh0 = 0; sh1 = 0; sh_addr = 0; prev_cs = 1'b0;
        end
        if (gi < gq.size() && gq[gi].cyc < tcyc) begin
          chk(1'b0, "gnt_missing", LAT, tcyc, gq[gi].cyc);
          gi++;
        end
        if (ri < rq.size() && rq[ri].cyc < tcyc) begin
          chk(1'b0, "rvalid_missing", LAT, tcyc, rq[ri].cyc);
          ri++;
        end
        if (gnt0 || gnt1) begin
          if (gi < gq.size()) begin
            e = gq[gi]; gi++;
            sh_addr = e.addr;
            chk(!(gnt0 && gnt1) && (int'(gnt1) == e.port) && e.cyc == tcyc &&
                rom_cs && rom_rd_en && int'(rom_addr) == e.addr,
                "gnt", LAT, tcyc * 10 + int'(gnt1), e.cyc * 10 + e.port);
          end else chk(1'b0, "gnt_unexpected", LAT, int'({gnt1, gnt0}), 0);
        end
        chk(rom_cs == (gnt0 | gnt1) && rom_rd_en == rom_cs && !(rom_cs && prev_cs),
            "rom_strobe", LAT, int'({prev_cs, rom_cs, rom_rd_en}), int'(gnt0 | gnt1));
        prev_cs = rom_cs;
        chk(int'(rom_addr) == sh_addr, "rom_addr", LAT, int'(rom_addr), sh_addr);
        if (rvalid0 || rvalid1) begin
          if (ri < rq.size()) begin
            e = rq[ri]; ri++;
            if (e.port == 1) sh1 = e.data; else sh0 = e.data;
            chk(!(rvalid0 && rvalid1) && (int'(rvalid1) == e.port) && e.cyc == tcyc,
                "rvalid", LAT, tcyc * 10 + int'(rvalid1), e.cyc * 10 + e.port);
          end else chk(1'b0, "rvalid_unexpected", LAT, int'({rvalid1, rvalid0}), 0);
        end
        chk(int'(rdata0) == sh0 && int'(rdata1) == sh1, "rdata", LAT,
            int'({rdata1, rdata0}), sh1 * 16 + sh0);
        bexp = (tcyc >= start) && (tcyc <= start + LAT + 1);
        chk(busy == bexp, "busy", LAT, int'(busy), int'(bexp));
        if (done && !fin) begin
          fin = 1'b1;
          chk(gi == gq.size() && ri == rq.size(), "drain", LAT,
              (gq.size() - gi) + (rq.size() - ri), 0);
        end
      end
    end
  end

  // Stimulus: reset with noise, sustained tie, sustained single requester,
  // then random traffic with occasional mid-transaction resets.
  initial begin
    checks = 0; failures = 0; done = 1'b0;
    rst = 1'b1; req0 = 1'($urandom); req1 = 1'($urandom);
    addr0 = 2'($urandom); addr1 = 2'($urandom);
    repeat (2) begin
      @(negedge clk);
      req0 = 1'($urandom); req1 = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 2'd1; addr1 = 2'd3;
    repeat (24) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) @(negedge clk);
    req0 = 1'b1; addr0 = 2'd2;
    @(negedge clk);
    req0 = 1'b0;
    repeat (8) @(negedge clk);
    req1 = 1'b1; addr1 = 2'd2;
    repeat (20) @(negedge clk);
    req1 = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(49) == 0);
      if (req0) begin
        if ($urandom_range(5) == 0) req0 = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        req0 = 1'b1; addr0 = 2'($urandom);
      end
      if (req1) begin
        if ($urandom_range(5) == 0) req1 = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        req1 = 1'b1; addr1 = 2'($urandom);
      end
      @(negedge clk);
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (20) @(negedge clk);
    done = 1'b1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
